aes_job_ctrl: RTL and testbench

Job sequencer in front of the AES-128 stream engine. It accepts a job (128-bit key plus block count) and clears and enables the engine. It forwards plaintext words from a source stream into the engine word port while replaying the latched key, four words per block, on the engine key port. It forwards engine output to a sink stream, counts completed words, and signals job completion.

---
 rtl/aes_job_ctrl.sv | 171 +++++++++++++++++
 tb/tb_aes_job_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_job_ctrl.sv
// Job sequencer for the AES-128 stream engine: latches key and block count, clears and enables the engine.
// Latency: zero-cycle combinational passthrough on the word, key and output streams while running.
// Backpressure: ready/valid on every stream; every stream is held idle outside the RUN phase.
module aes_job_ctrl #(
   parameter int unsigned BLOCK_CNT_W = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic                   clear_i,
   input  logic [BLOCK_CNT_W-1:0] num_blocks_i,
   input  logic [127:0]           key_i,
   input  logic                   src_valid_i,
   output logic                   src_ready_o,
   input  logic [31:0]            src_data_i,
   output logic                   word_valid_o,
   input  logic                   word_ready_i,
   output logic [31:0]            word_data_o,
   output logic                   key_valid_o,
   input  logic                   key_ready_i,
   output logic [31:0]            key_data_o,
   input  logic                   eng_valid_i,
   output logic                   eng_ready_o,
   input  logic [31:0]            eng_data_i,
   output logic                   dst_valid_o,
   input  logic                   dst_ready_i,
   output logic [31:0]            dst_data_o,
   output logic                   eng_clear_o,
   output logic                   eng_enable_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [BLOCK_CNT_W-1:0] blocks_done_o
);
   // Word counters must hold 4*N for the largest N, hence two extra bits.
   localparam int unsigned CW = BLOCK_CNT_W + 2;

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_e;

   state_e                 state_q, state_d;
   logic [127:0]           key_q, key_d;
   logic [BLOCK_CNT_W-1:0] nblk_q, nblk_d;
   logic [CW-1:0]          in_cnt_q, in_cnt_d;
   logic [CW-1:0]          key_cnt_q, key_cnt_d;
   logic [CW-1:0]          out_cnt_q, out_cnt_d;
   logic                   abort_q, abort_d;
   logic [CW-1:0]          limit;
   logic                   in_open, key_open, out_open;
   logic [31:0]            key_word;

   // Total words per job; every counter stops here, so nothing wraps inside a job.
   assign limit    = {nblk_q, 2'b00};
   assign in_open  = (in_cnt_q < limit);
   assign key_open = (key_cnt_q < limit);
   assign out_open = (out_cnt_q < limit);

   assign busy_o        = (state_q != S_IDLE);
   assign eng_enable_o  = busy_o;
   assign blocks_done_o = out_cnt_q[CW-1:2];

   // Key word replay: the low two bits of the key counter pick the word, MSB word first.
   always_comb begin
      key_word = key_q[127:96];
      case (key_cnt_q[1:0])
         2'd0: key_word = key_q[127:96];
         2'd1: key_word = key_q[95:64];
         2'd2: key_word = key_q[63:32];
         2'd3: key_word = key_q[31:0];
         default: key_word = key_q[127:96];
      endcase
   end

   // Next-state, counter and stream-output logic; streams are quiet except in RUN.
   always_comb begin
      state_d      = state_q;
      key_d        = key_q;
      nblk_d       = nblk_q;
      in_cnt_d     = in_cnt_q;
      key_cnt_d    = key_cnt_q;
      out_cnt_d    = out_cnt_q;
      abort_d      = 1'b0;
      src_ready_o  = 1'b0;
      word_valid_o = 1'b0;
      word_data_o  = '0;
      key_valid_o  = 1'b0;
      key_data_o   = '0;
      eng_ready_o  = 1'b0;
      dst_valid_o  = 1'b0;
      dst_data_o   = '0;
      eng_clear_o  = abort_q;
      done_o       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               key_d     = key_i;
               nblk_d    = num_blocks_i;
               in_cnt_d  = '0;
               key_cnt_d = '0;
               out_cnt_d = '0;
               // An empty job skips the engine clear and reports completion directly.
               state_d   = (num_blocks_i != '0) ? S_CLEAR : S_DONE;
            end
         end
         S_CLEAR: begin
            eng_clear_o = 1'b1;
            state_d     = S_RUN;
         end
         S_RUN: begin
            word_valid_o = src_valid_i & in_open;
            src_ready_o  = word_ready_i & in_open;
            word_data_o  = src_data_i;
            key_valid_o  = key_open;
            key_data_o   = key_word;
            dst_valid_o  = eng_valid_i;
            eng_ready_o  = dst_ready_i;
            dst_data_o   = eng_data_i;
            if (src_valid_i && word_ready_i && in_open) begin
               in_cnt_d = in_cnt_q + 1'b1;
            end
            if (key_open && key_ready_i) begin
               key_cnt_d = key_cnt_q + 1'b1;
            end
            if (eng_valid_i && dst_ready_i && out_open) begin
               out_cnt_d = out_cnt_q + 1'b1;
               if (out_cnt_d == limit) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Abort wins over everything else; the engine clear is issued from a flag next cycle.
      if (clear_i && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         abort_d = 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Job context, counters and abort flag.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         key_q     <= '0;
         nblk_q    <= '0;
         in_cnt_q  <= '0;
         key_cnt_q <= '0;
         out_cnt_q <= '0;
         abort_q   <= 1'b0;
      end else begin
         key_q     <= key_d;
         nblk_q    <= nblk_d;
         in_cnt_q  <= in_cnt_d;
         key_cnt_q <= key_cnt_d;
         out_cnt_q <= out_cnt_d;
         abort_q   <= abort_d;
      end
   end
endmodule

// File: tb/tb_aes_job_ctrl.sv
// Bench for aes_job_ctrl: a table of jobs runs against a behavioural engine and stream model.
// Each job checks stream gating, data ordering, key replay, clear/done timing and counts.
module tb_aes_job_ctrl;
   localparam int BW = 16;
   localparam logic [127:0] K1 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
   localparam logic [127:0] K2 = 128'h00010203_04050607_08090a0b_0c0d0e0f;

   typedef struct {
      int          n;
      logic [127:0] key;
      int          mode;      // 0 all ready, 1 dst_ready toggling, 2 random handshakes
      bit          hold;      // keep start_i high for the whole job
      int          kill;      // 0 none, 1 clear_i abort, 2 rst_i
      int          kill_at;   // output count at which the kill is applied
      int          exp_outs;
      int          exp_keys;  // negative: not checked
      int          exp_blocks;// negative: not checked
      int          exp_dones;
      int          exp_clears;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_i, start_i, clear_i;
   logic [BW-1:0] num_blocks_i;
   logic [127:0]  key_i;
   logic          src_valid_i, src_ready_o;
   logic [31:0]   src_data_i;
   logic          word_valid_o, word_ready_i;
   logic [31:0]   word_data_o;
   logic          key_valid_o, key_ready_i;
   logic [31:0]   key_data_o;
   logic          eng_valid_i, eng_ready_o;
   logic [31:0]   eng_data_i;
   logic          dst_valid_o, dst_ready_i;
   logic [31:0]   dst_data_o;
   logic          eng_clear_o, eng_enable_o, busy_o, done_o;
   logic [BW-1:0] blocks_done_o;

   logic [31:0]   pt1 [4] = '{32'h6bc1bee2, 32'h2e409f96, 32'he93d7e11, 32'h7393172a};
   int            errors = 0;
   int            checks = 0;

   always #5 clk = ~clk;

   aes_job_ctrl #(.BLOCK_CNT_W(BW)) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .clear_i(clear_i),
      .num_blocks_i(num_blocks_i), .key_i(key_i),
      .src_valid_i(src_valid_i), .src_ready_o(src_ready_o), .src_data_i(src_data_i),
      .word_valid_o(word_valid_o), .word_ready_i(word_ready_i), .word_data_o(word_data_o),
      .key_valid_o(key_valid_o), .key_ready_i(key_ready_i), .key_data_o(key_data_o),
      .eng_valid_i(eng_valid_i), .eng_ready_o(eng_ready_o), .eng_data_i(eng_data_i),
      .dst_valid_o(dst_valid_o), .dst_ready_i(dst_ready_i), .dst_data_o(dst_data_o),
      .eng_clear_o(eng_clear_o), .eng_enable_o(eng_enable_o), .busy_o(busy_o),
      .done_o(done_o), .blocks_done_o(blocks_done_o)
   );

   initial begin
      #900000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog expired");
   end

   // Stand-in for the cipher: any fixed bijection is enough to prove ordering.
   function automatic logic [31:0] eng_f(input logic [31:0] x);
      return {x[15:0], x[31:16]} ^ 32'h5A5AC3C3;
   endfunction

   function automatic logic [31:0] key_word(input logic [127:0] k, input int j);
      return k[127 - 32*j -: 32];
   endfunction

   function automatic bit rnd(input int mode);
      return (mode != 2) || ($urandom_range(0, 3) != 0);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_stream_ctl"}, {word_valid_o, src_ready_o, key_valid_o, dst_valid_o, eng_ready_o}, 0);
      chk({tag, "_stream_dat"}, word_data_o | key_data_o | dst_data_o, 0);
   endtask

   task automatic drive_idle();
      src_valid_i = 0; src_data_i = 0; word_ready_i = 0; key_ready_i = 0;
      eng_valid_i = 0; eng_data_i = 0; dst_ready_i = 0;
   endtask

   // Runs one job from an idle cycle (entered and left at posedge+1).
   task automatic run_job(input vec_t v, output int outs, output int keys,
                          output int dones, output int clears);
      logic [31:0] src[$];
      logic [31:0] engq[$];
      int words, lim, budget;
      bit fin, was_fin, in_run, exp_clear, kill_now, finished;
      lim = 4 * v.n;
      budget = 8 * lim + 40;
      for (int i = 0; i < lim + 2; i++) src.push_back(i < 4 ? pt1[i] : $urandom());
      outs = 0; keys = 0; dones = 0; clears = 0; words = 0;
      fin = (v.n == 0); finished = 0;
      start_i = 1; num_blocks_i = BW'(v.n); key_i = v.key;
      @(negedge clk);
      chk("pre_start_busy", busy_o, 0);
      @(posedge clk); #1;
      // Scramble the job inputs: only the latched copies may be used from here on.
      start_i = v.hold; num_blocks_i = BW'($urandom());
      key_i = {$urandom(), $urandom(), $urandom(), $urandom()};
      for (int cyc = 0; cyc < budget && !finished; cyc++) begin
         was_fin   = fin;
         in_run    = (v.n > 0) && (cyc >= 1) && !fin;
         exp_clear = (v.n > 0) && (cyc == 0);
         if (was_fin) start_i = 0;
         src_valid_i  = (words < src.size()) && rnd(v.mode);
         src_data_i   = (words < src.size()) ? src[words] : 32'h0;
         word_ready_i = rnd(v.mode);
         key_ready_i  = rnd(v.mode);
         eng_valid_i  = (engq.size() > 0) && rnd(v.mode);
         eng_data_i   = (engq.size() > 0) ? eng_f(engq[0]) : 32'h0;
         dst_ready_i  = (v.mode == 1) ? (cyc % 2 == 0) : rnd(v.mode);
         kill_now = (v.kill != 0) && in_run && (outs == v.kill_at);
         if (kill_now) begin
            drive_idle();
            if (v.kill == 1) clear_i = 1; else rst_i = 1;
         end
         @(negedge clk);
         chk("busy", busy_o, 1);
         chk("enable", eng_enable_o, 1);
         chk("done", done_o, was_fin);
         chk("eng_clear", eng_clear_o, exp_clear);
         if (v.n > 0) chk("blocks_done", blocks_done_o, outs / 4);
         if (eng_clear_o) begin clears++; engq = {}; end
         if (done_o) dones++;
         if (in_run) begin
            chk("word_valid", word_valid_o, src_valid_i && (words < lim));
            chk("src_ready", src_ready_o, word_ready_i && (words < lim));
            chk("key_valid", key_valid_o, keys < lim);
            chk("dst_valid", dst_valid_o, eng_valid_i);
            chk("eng_ready", eng_ready_o, dst_ready_i);
            if (dst_valid_o && dst_ready_i) begin
               chk("dst_data", dst_data_o, eng_f(src[outs]));
               outs++;
               if (engq.size() > 0) void'(engq.pop_front());
               if (outs == lim) fin = 1;
            end
            if (word_valid_o && word_ready_i) begin
               chk("word_data", word_data_o, src[words]);
               engq.push_back(word_data_o);
               words++;
            end
            if (key_valid_o && key_ready_i) begin
               chk("key_data", key_data_o, key_word(v.key, keys % 4));
               keys++;
            end
         end else begin
            chk_quiet("idle");
         end
         if (kill_now) begin
            @(posedge clk); #1;
            clear_i = 0; rst_i = 0; engq = {};
            @(negedge clk);
            chk("kill_busy", busy_o, 0);
            chk("kill_done", done_o, 0);
            chk("kill_eng_clear", eng_clear_o, v.kill == 1);
            chk("kill_blocks", blocks_done_o, (v.kill == 1) ? outs / 4 : 0);
            chk_quiet("kill");
            if (eng_clear_o) clears++;
            @(posedge clk); #1;
            @(negedge clk);
            chk("kill_clear_len", eng_clear_o, 0);
            chk("kill_idle", busy_o, 0);
            finished = 1;
         end else if (was_fin) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("post_done_busy", busy_o, 0);
            chk("post_done_pulse", done_o, 0);
            finished = 1;
         end
         @(posedge clk); #1;
      end
      if (!finished) begin
         checks++; errors++;
         $display("FAIL timeout: job N=%0d got %0d of %0d outputs", v.n, outs, lim);
      end
   endtask

   initial begin
      vec_t vecs[10];
      int o, k, d, c;
      vecs[0] = '{n:1,    key:K1, mode:0, hold:0, kill:0, kill_at:0, exp_outs:4,    exp_keys:4,    exp_blocks:1,    exp_dones:1, exp_clears:1};
      vecs[1] = '{n:4,    key:K1, mode:1, hold:0, kill:0, kill_at:0, exp_outs:16,   exp_keys:16,   exp_blocks:4,    exp_dones:1, exp_clears:1};
      vecs[2] = '{n:0,    key:K2, mode:0, hold:0, kill:0, kill_at:0, exp_outs:0,    exp_keys:0,    exp_blocks:-1,   exp_dones:1, exp_clears:0};
      vecs[3] = '{n:4,    key:K2, mode:0, hold:0, kill:1, kill_at:6, exp_outs:6,    exp_keys:-1,   exp_blocks:1,    exp_dones:0, exp_clears:2};
      vecs[4] = '{n:1,    key:K1, mode:2, hold:0, kill:0, kill_at:0, exp_outs:4,    exp_keys:4,    exp_blocks:1,    exp_dones:1, exp_clears:1};
      vecs[5] = '{n:2,    key:K2, mode:2, hold:1, kill:0, kill_at:0, exp_outs:8,    exp_keys:8,    exp_blocks:2,    exp_dones:1, exp_clears:1};
      vecs[6] = '{n:3,    key:K1, mode:2, hold:0, kill:0, kill_at:0, exp_outs:12,   exp_keys:12,   exp_blocks:3,    exp_dones:1, exp_clears:1};
      vecs[7] = '{n:1024, key:K2, mode:0, hold:0, kill:0, kill_at:0, exp_outs:4096, exp_keys:4096, exp_blocks:1024, exp_dones:1, exp_clears:1};
      vecs[8] = '{n:2,    key:K1, mode:0, hold:0, kill:2, kill_at:3, exp_outs:3,    exp_keys:-1,   exp_blocks:0,    exp_dones:0, exp_clears:1};
      vecs[9] = '{n:1,    key:K2, mode:1, hold:0, kill:0, kill_at:0, exp_outs:4,    exp_keys:4,    exp_blocks:1,    exp_dones:1, exp_clears:1};

      // Reset with busy-looking inputs: everything must stay quiet.
      rst_i = 1; start_i = 1; clear_i = 1; num_blocks_i = '1; key_i = '1;
      src_valid_i = 1; src_data_i = '1; word_ready_i = 1; key_ready_i = 1;
      eng_valid_i = 1; eng_data_i = '1; dst_ready_i = 1;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_busy", busy_o, 0);
      chk("rst_enable", eng_enable_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_eng_clear", eng_clear_o, 0);
      chk("rst_blocks", blocks_done_o, 0);
      chk_quiet("rst");
      @(posedge clk); #1;
      rst_i = 0; start_i = 0; clear_i = 0; drive_idle();

      // clear_i in IDLE must not produce an engine clear.
      clear_i = 1;
      @(posedge clk); #1;
      clear_i = 0;
      @(negedge clk);
      chk("idle_clear_ignored", eng_clear_o, 0);
      chk("idle_clear_busy", busy_o, 0);
      @(posedge clk); #1;

      for (int i = 0; i < 10; i++) begin
         run_job(vecs[i], o, k, d, c);
         chk($sformatf("job%0d_outs", i), o, vecs[i].exp_outs);
         if (vecs[i].exp_keys >= 0) chk($sformatf("job%0d_keys", i), k, vecs[i].exp_keys);
         chk($sformatf("job%0d_dones", i), d, vecs[i].exp_dones);
         chk($sformatf("job%0d_clears", i), c, vecs[i].exp_clears);
         if (vecs[i].exp_blocks >= 0) chk($sformatf("job%0d_blocks", i), blocks_done_o, vecs[i].exp_blocks);
         drive_idle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
